// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UARTsend transmitter among NUM_REQ byte requesters.
// Round-robin arbitration per packet; a requester that starts a multi-byte packet
// keeps the transmitter until its last byte. Issue pacing follows BufFull.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDW       = 2,
    parameter int GUARD_CYC = 2
) (
    input  logic                 clk16x,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 TransEn,
    output logic [7:0]           DataToTrans,
    input  logic                 BufFull,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy
);

    localparam int GW = (GUARD_CYC < 1) ? 1 : $clog2(GUARD_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  guard_q, guard_d;
    logic [7:0]     data_q, data_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic           locked_q, locked_d;

    logic [IDW-1:0] cand;
    logic [IDW-1:0] rr_sel;
    logic           rr_hit;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] sel_next;
    logic           sel_valid;
    logic           hs;

    // Round-robin scan: first valid requester starting at rr_q, wrapping.
    always_comb begin
        cand   = '0;
        rr_sel = '0;
        rr_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((32'(rr_q) + i) % NUM_REQ);
            if (!rr_hit && req_valid[cand]) begin
                rr_sel = cand;
                rr_hit = 1'b1;
            end
        end
    end

    // Grant selection and handshake; a held lock pins selection to its owner.
    always_comb begin
        sel       = locked_q ? owner_q : rr_sel;
        sel_valid = locked_q ? req_valid[owner_q] : rr_hit;
        hs        = (state_q == S_IDLE) && !BufFull && sel_valid;
        sel_next  = (32'(sel) + 32'd1 == 32'(NUM_REQ)) ? '0 : sel + 1'b1;
        req_ready = '0;
        if (hs) begin
            req_ready[sel] = 1'b1;
        end
    end

    // Next-state logic: accept byte, pulse TransEn, guard, wait for BufFull to clear.
    always_comb begin
        state_d  = state_q;
        guard_d  = guard_q;
        data_d   = data_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        locked_d = locked_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    data_d  = req_data[{sel, 3'b000} +: 8];
                    grant_d = sel;
                    state_d = S_ISSUE;
                    if (req_last[sel]) begin
                        locked_d = 1'b0;
                        rr_d     = sel_next;
                    end else begin
                        locked_d = 1'b1;
                        owner_d  = sel;
                    end
                end
            end
            S_ISSUE: begin
                guard_d = GW'(GUARD_CYC);
                state_d = (GUARD_CYC == 0) ? S_WAIT_DONE : S_GUARD;
            end
            S_GUARD: begin
                // Counter holds the guard cycles left including this one.
                guard_d = guard_q - 1'b1;
                if (guard_d == '0) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!BufFull) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk16x) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            guard_q  <= '0;
            data_q   <= '0;
            grant_q  <= '0;
            rr_q     <= '0;
            owner_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            data_q   <= data_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
        end
    end

    assign TransEn     = (state_q == S_ISSUE);
    assign DataToTrans = data_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != S_IDLE) | locked_q;

endmodule
